// File: rtl/pipelined_fetch_issue.sv
// Front end: PC register, synchronous imem fetch, one-word skid buffer and the
// issue register feeding decode. Bubbles on stall, kills wrong-path words on squash.
module pipelined_fetch_issue #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_input,
  input  logic        pc_en,
  input  logic        squash_issue,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] issue_instr,
  output logic [31:0] issue_pc,
  output logic        issue_valid
);

  logic [31:0] pc_q;
  logic [31:0] fetch_pc_q;
  logic        fetch_valid_q;
  logic [31:0] skid_data_q;
  logic        skid_valid_q;
  logic [31:0] iss_instr_q;
  logic [31:0] iss_pc_q;
  logic        iss_valid_q;
  logic [31:0] f2_data;

  // Once stalled, imem_rdata moves on to the next address, so the word that
  // belonged to F2 must come from the skid buffer.
  assign f2_data = skid_valid_q ? skid_data_q : imem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      fetch_pc_q    <= 32'h0;
      fetch_valid_q <= 1'b0;
      skid_data_q   <= 32'h0;
      skid_valid_q  <= 1'b0;
      iss_instr_q   <= NOP_INSTR;
      iss_pc_q      <= 32'h0;
      iss_valid_q   <= 1'b0;
    end else if (pc_en) begin
      pc_q         <= pc_input;
      fetch_pc_q   <= pc_q;
      skid_valid_q <= 1'b0;
      if (squash_issue) begin
        fetch_valid_q <= 1'b0;
        iss_instr_q   <= NOP_INSTR;
        iss_pc_q      <= 32'h0;
        iss_valid_q   <= 1'b0;
      end else begin
        fetch_valid_q <= 1'b1;
        iss_instr_q   <= fetch_valid_q ? f2_data : NOP_INSTR;
        iss_pc_q      <= fetch_pc_q;
        iss_valid_q   <= fetch_valid_q;
      end
    end else if (fetch_valid_q && !skid_valid_q) begin
      // Squash is deliberately ignored here; pc_control reasserts it after release.
      skid_data_q  <= imem_rdata;
      skid_valid_q <= 1'b1;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign issue_valid = iss_valid_q & pc_en;
  assign issue_instr = issue_valid ? iss_instr_q : NOP_INSTR;
  assign issue_pc    = iss_pc_q;

endmodule

// File: tb/tb_pipelined_fetch_issue.sv
// Bench for pipelined_fetch_issue: directed reset/stall/squash scenarios then random
// traffic, checked against an in-order queue of right-path fetched PCs.
module tb_pipelined_fetch_issue;

  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_input = 32'h0;
  logic        pc_en = 1'b0;
  logic        squash_issue = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] issue_instr;
  logic [31:0] issue_pc;
  logic        issue_valid;

  pipelined_fetch_issue #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .pc_input(pc_input), .pc_en(pc_en),
    .squash_issue(squash_issue), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .pc(pc), .issue_instr(issue_instr), .issue_pc(issue_pc), .issue_valid(issue_valid)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) imem_rdata <= mem[imem_addr[7:0]];

  // Model: PCs fetched on the right path and not yet issued, oldest first.
  logic [31:0] fetched_q [$];
  logic [31:0] m_pc = RESET_PC;
  bit          started = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic sq, input logic [31:0] pin);
    logic        exp_v;
    logic [31:0] head;
    @(negedge clk);
    rst_n = r; pc_en = en; squash_issue = sq; pc_input = pin;
    #1;
    // An issued word must have been fetched exactly two advancing cycles earlier.
    exp_v = en && (fetched_q.size() == 2);
    head  = (fetched_q.size() > 0) ? fetched_q[0] : 32'h0;
    if (started) begin
      check_value("pc", pc, m_pc);
      check_value("imem_addr", imem_addr, m_pc);
      check_value("issue_valid", {31'h0, issue_valid}, {31'h0, exp_v});
      check_value("issue_instr", issue_instr, exp_v ? mem[head[7:0]] : NOP_INSTR);
      if (exp_v) check_value("issue_pc", issue_pc, head);
    end
    $display("cyc rst_n=%0b en=%0b sq=%0b pc=%h valid=%0b instr=%h ipc=%h",
             r, en, sq, pc, issue_valid, issue_instr, issue_pc);
    @(posedge clk);
    if (!r) begin
      fetched_q.delete();
      m_pc    = RESET_PC;
      started = 1'b1;
    end else if (en) begin
      if (exp_v) void'(fetched_q.pop_front());
      if (sq) fetched_q.delete();
      else    fetched_q.push_back(m_pc);
      m_pc = pin;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = (i < 128) ? (32'h100 + i) : $urandom;

    // Reset held for two cycles.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Straight line: issues pc 0..3, then stall 3 cycles while pc=4 sits in issue.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, m_pc + 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, m_pc + 1);
    while (m_pc != 32'h7) step(1'b1, 1'b1, 1'b0, m_pc + 1);

    // Taken jump from pc=7 to 0x40.
    step(1'b1, 1'b1, 1'b1, 32'h40);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, m_pc + 1);

    // Squash while stalled is ignored, then reasserted with pc_en.
    step(1'b1, 1'b0, 1'b1, 32'h60);
    step(1'b1, 1'b0, 1'b1, 32'h60);
    step(1'b1, 1'b1, 1'b1, 32'h60);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, m_pc + 1);

    // Reset in the middle of a stall with the skid buffer full.
    step(1'b1, 1'b0, 1'b0, m_pc + 1);
    step(1'b1, 1'b0, 1'b0, m_pc + 1);
    step(1'b0, 1'b0, 1'b0, m_pc + 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, m_pc + 1);

    // PC wrap passes straight through.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, m_pc + 1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic        r, en, sq;
      logic [31:0] pin;
      r   = ($urandom_range(0, 99) != 0);
      en  = ($urandom_range(0, 3) != 0);
      sq  = ($urandom_range(0, 9) == 0);
      pin = sq ? $urandom : m_pc + 1;
      step(r, en, sq, pin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
